// File: rtl/led_pulse_pkg.sv
// Shared types and helpers for the LED pulse stretcher: FSM state encoding and timer width.
package led_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } led_state_t;

    // Timer must hold max(on, off) - 1; never narrower than one bit.
    function automatic int cnt_width(input int on_cycles, input int off_cycles);
        int m;
        int w;
        m = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/led_pulse_stretcher_stretch_timer.sv
// Loadable down-counter shared by the ON and GAP phases; holds at zero when not loaded.
module stretch_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches one-cycle events into ON_CYCLES LED flashes, each followed by an OFF_CYCLES dark gap.
// LED_PULSE_QUEUE_EN: events arriving mid-flash are queued (saturating) instead of dropped.
module led_pulse_stretcher #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int PEND_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              dropped
);
    import led_pulse_pkg::*;

    localparam int CW = cnt_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

    led_state_t        state;
    led_state_t        state_next;
    logic              load;
    logic [CW-1:0]     load_val;
    logic              zero;
    logic              final_gap;
    logic              start;
    logic              drop_next;
    logic [PEND_W-1:0] pend_q;

    stretch_timer #(.W(CW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (load_val),
        .zero  (zero)
    );

    assign final_gap = (state == GAP) && zero;
    assign start     = final_gap && ((pend_q != '0) || pulse_in);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_val   = ON_LOAD;
        case (state)
            IDLE: begin
                if (pulse_in) begin
                    state_next = ON;
                    load       = 1'b1;
                end
            end
            ON: begin
                if (zero) begin
                    state_next = GAP;
                    load       = 1'b1;
                    load_val   = OFF_LOAD;
                end
            end
            GAP: begin
                if (zero) begin
                    state_next = start ? ON : IDLE;
                    load       = start;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef LED_PULSE_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    logic [PEND_W-1:0] pend_next;

    always_comb begin
        pend_next = pend_q;
        drop_next = 1'b0;
        if (final_gap) begin
            // start is always 1 when pulse_in is, so this cannot overflow or underflow
            pend_next = pend_q + PEND_W'(pulse_in) - PEND_W'(start);
        end else if (pulse_in && (state != IDLE)) begin
            if (pend_q == PEND_MAX) begin
                drop_next = 1'b1;
            end else begin
                pend_next = pend_q + PEND_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_next;
        end
    end
`else
    assign pend_q    = '0;
    assign drop_next = pulse_in && (state != IDLE) && !final_gap;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            led_out <= 1'b0;
            busy    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= state_next;
            led_out <= (state_next == ON);
            busy    <= (state_next != IDLE);
            dropped <= drop_next;
        end
    end

    assign pending = pend_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with ON=4, OFF=2, PEND_W=2; per-cycle expectations as bit vectors.
module tb_led_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse_in = 1'b0;
    logic       led_out;
    logic       busy;
    logic [1:0] pending;
    logic       dropped;

    int checks = 0;
    int errors = 0;

    led_pulse_stretcher #(
        .ON_CYCLES  (4),
        .OFF_CYCLES (2),
        .PEND_W     (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .led_out  (led_out),
        .busy     (busy),
        .pending  (pending),
        .dropped  (dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pulses[c] is driven during cycle c; expectation bit c describes cycle c.
    task automatic run(input string tag, input int ncyc, input logic [31:0] pulses,
                       input logic [31:0] led_e, input logic [31:0] busy_e,
                       input logic [31:0] drop_e, input logic [31:0] p0_e,
                       input logic [31:0] p1_e);
        for (int c = 0; c <= ncyc; c++) begin
            chk($sformatf("%s c%0d led", tag, c), {7'd0, led_out}, {7'd0, led_e[c]});
            chk($sformatf("%s c%0d busy", tag, c), {7'd0, busy}, {7'd0, busy_e[c]});
            chk($sformatf("%s c%0d dropped", tag, c), {7'd0, dropped}, {7'd0, drop_e[c]});
            chk($sformatf("%s c%0d pending", tag, c), {6'd0, pending}, {6'd0, p1_e[c], p0_e[c]});
            if (c < ncyc) begin
                pulse_in = pulses[c];
                @(posedge clk);
                #1;
            end
        end
        pulse_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pulse_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset led", {7'd0, led_out}, 8'd0);
        chk("reset busy", {7'd0, busy}, 8'd0);
        chk("reset pending", {6'd0, pending}, 8'd0);
        chk("reset dropped", {7'd0, dropped}, 8'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single pulse: LED 1-4, dark 5-6, idle from 7
        run("single", 10, 32'h1, 32'h1E, 32'h7E, 32'h0, 32'h0, 32'h0);

        // pulse on the final GAP cycle with nothing pending: consumed directly
        run("final_gap", 14, 32'h41, 32'h79E, 32'h1FFE, 32'h0, 32'h0, 32'h0);

`ifdef LED_PULSE_QUEUE_EN
        // pulses 0,2,3: pending 1 in c3, 2 in c4-6, 1 in c7-12
        run("queue3", 22, 32'hD, 32'h1E79E, 32'h7FFFE, 32'h0, 32'h1F88, 32'h70);

        // pulses 0-4: saturate at 3, drop the fifth, four bursts
        run("saturate", 26, 32'h1F, 32'h79E79E, 32'h1FFFFFE, 32'h20, 32'h7E074, 32'h1FF8);
`else
        // second pulse mid-ON is discarded
        run("drop", 8, 32'h5, 32'h1E, 32'h7E, 32'h8, 32'h0, 32'h0);
`endif

        // reset mid-ON: outputs clear without waiting for a clock edge
        pulse_in = 1'b1;
        @(posedge clk);
        #1;
        pulse_in = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-reset led", {7'd0, led_out}, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async led", {7'd0, led_out}, 8'd0);
        chk("async busy", {7'd0, busy}, 8'd0);
        chk("async pending", {6'd0, pending}, 8'd0);
        chk("async dropped", {7'd0, dropped}, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("after_rst", 10, 32'h1, 32'h1E, 32'h7E, 32'h0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pulse_stretcher.md
# led_pulse_stretcher

Converts single-cycle event pulses (the output format of the button debounce/one-pulse front end) into human-visible LED flashes. Each accepted pulse produces one LED-on window of fixed length followed by a mandatory dark gap, so back-to-back events stay distinguishable. The block sits between game logic and the Basys3 LED pins. It is the output-side counterpart of the button input conditioning.

## Interface
- `ON_CYCLES`, default 25_000_000: LED-on window length in `clk` cycles; must be ≥1.
- `OFF_CYCLES`, default 12_500_000: dark gap after each window in `clk` cycles; must be ≥1.
- `PEND_W`, default 3: width of the pending-event counter; maximum queued events = 2^PEND_W−1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pulse_in`  in  1  single-cycle event request, sampled every rising edge.
- `led_out`  out  1  registered LED drive; 1 during an ON window.
- `busy`  out  1  registered; 1 whenever state ≠ IDLE.
- `pending`  out  PEND_W  registered count of queued, not-yet-shown events.
- `dropped`  out  1  registered one-cycle pulse; 1 when an event was discarded.

## Operation
- States: IDLE, ON, GAP. A single down-counter is shared by ON and GAP. Its width is `$clog2(max(ON_CYCLES,OFF_CYCLES))`, minimum 1.
- IDLE, `pulse_in`=1: go to ON and load the counter with ON_CYCLES−1. `led_out`=1 from the next cycle.
- ON: decrement each cycle. When the counter is 0, go to GAP and load OFF_CYCLES−1.
- GAP: decrement each cycle. On the final GAP cycle (counter 0), compute `start = (pending≠0) | pulse_in`.
  - `start`=1: go to ON and load ON_CYCLES−1.
  - `start`=0: go to IDLE.
- Pending update on the final GAP cycle: `pending_next = pending + pulse_in − start`. A pulse arriving there with `pending`=0 is consumed directly, and `pending` stays 0.
- A pulse in any other ON/GAP cycle is handled per the Configuration section.
- Reset, including mid-window: state=IDLE, counter=0, `led_out`=0, `busy`=0, `pending`=0, `dropped`=0. The outputs clear asynchronously.

## Timing
- Latency from `pulse_in` sampled in IDLE to `led_out` rising: 1 cycle.
- Each burst: `led_out` high for exactly ON_CYCLES cycles, then low for exactly OFF_CYCLES cycles.
- Back-to-back bursts repeat with period ON_CYCLES+OFF_CYCLES and no extra idle cycle between them.
- `busy` rises with `led_out` and falls 1 cycle after the last GAP cycle when nothing is left to show.
- `dropped` and `pending` reflect the `pulse_in` sampled on the previous edge.

## Configuration
- `LED_PULSE_QUEUE_EN` defined:
  - A `pulse_in` during ON or a non-final GAP cycle increments `pending`.
  - `pending` saturates at 2^PEND_W−1. A pulse arriving at saturation sets `dropped`=1 for one cycle and leaves `pending` unchanged.
  - Simultaneous pulse and dequeue on the final GAP cycle leave `pending` at the same value.
- `LED_PULSE_QUEUE_EN` undefined:
  - `pending` is tied to 0.
  - A pulse is accepted only in IDLE or on the final GAP cycle.
  - A pulse in any other non-IDLE cycle sets `dropped`=1 for one cycle and is discarded.

## Structure
- Shared package `led_pulse_pkg`: the state enum (IDLE/ON/GAP encoding) and a `clog2`-based counter-width helper constant function.
- One sub-module, `stretch_timer`:
  - loadable down-counter;
  - `load`/`value` inputs, `zero` flag output;
  - asynchronous active-high reset.
- The FSM, pending counter and output registers live in the top module.

## Test plan
All cases use ON_CYCLES=4, OFF_CYCLES=2, PEND_W=2; cycle 0 is the edge that samples the first pulse.
- Single pulse at cycle 0 → `led_out`=1 in cycles 1–4 and 0 in 5–6; `busy`=1 in cycles 1–6 and 0 in cycle 7; `dropped` never asserts.
- Queue enabled, pulses at cycles 0, 2, 3 → `pending` peaks at 2. LED high in cycles 1–4, 7–10 and 13–16. `busy` falls at cycle 19.
- Queue enabled, pulses at cycles 0–4 → 3 queued (`pending`=3). The 5th pulse gives `dropped`=1 in cycle 5. Exactly 4 bursts follow.
- Pulse on the final GAP cycle (cycle 6) with `pending`=0 → LED high in cycles 7–10; `pending` stays 0.
- `rst` asserted mid-ON (cycle 2) → `led_out`, `busy`, `pending` are 0 immediately. A pulse after release gives a fresh burst with 1-cycle latency.
- Queue disabled, pulses at cycles 0 and 2 → single burst in cycles 1–4; `dropped`=1 in cycle 3; `pending` stays 0.
